// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency/backpressure: none, declarations only.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        REQ    = 2'd2,
        RESUME = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // $zero is hardwired, so it can never create a dependency.
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != REG_ZERO) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_unit_forward.sv
// Forwarding select generation for the D and E stages.
// Latency: purely combinational; backpressure: none.
module hazard_unit_forward
    import hazard_pkg::*;
(
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rt_e_i,
    input  logic [4:0] write_reg_m_i,
    input  logic [4:0] write_reg_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic       forward_ad_o,
    output logic       forward_bd_o,
    output logic [1:0] forward_ae_o,
    output logic [1:0] forward_be_o
);

    always_comb begin
        forward_ae_o = FWD_RF;
        forward_be_o = FWD_RF;
        // M is the younger producer, so it wins over W.
        if (reg_write_m_i && reg_hit(write_reg_m_i, rs_e_i)) begin
            forward_ae_o = FWD_MEM;
        end else if (reg_write_w_i && reg_hit(write_reg_w_i, rs_e_i)) begin
            forward_ae_o = FWD_WB;
        end
        if (reg_write_m_i && reg_hit(write_reg_m_i, rt_e_i)) begin
            forward_be_o = FWD_MEM;
        end else if (reg_write_w_i && reg_hit(write_reg_w_i, rt_e_i)) begin
            forward_be_o = FWD_WB;
        end
    end

    assign forward_ad_o = reg_write_m_i && reg_hit(write_reg_m_i, rs_d_i);
    assign forward_bd_o = reg_write_m_i && reg_hit(write_reg_m_i, rt_d_i);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush/forward control plus syscall drain and req/ack handoff FSM.
// Latency: stalls and forwards are combinational; sys_req rises DRAIN_CYCLES edges after syscallE; the front end stays frozen until ack.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       syscallE,
    input  logic       sys_ack,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       sys_req,
    output logic       sys_err,
    output logic       SysActive
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            sys_req_q, sys_req_d;
    logic            sys_err_q, sys_err_d;
    logic            lwstall, brstall, hold;
    logic            fwd_ad, fwd_bd;
    logic [1:0]      fwd_ae, fwd_be;

    hazard_unit_forward u_fwd (
        .rs_d_i        (RsD),
        .rt_d_i        (RtD),
        .rs_e_i        (RsE),
        .rt_e_i        (RtE),
        .write_reg_m_i (WriteRegM),
        .write_reg_w_i (WriteRegW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .forward_ad_o  (fwd_ad),
        .forward_bd_o  (fwd_bd),
        .forward_ae_o  (fwd_ae),
        .forward_be_o  (fwd_be)
    );

    assign lwstall = MemtoRegE && (reg_hit(RtE, RsD) || reg_hit(RtE, RtD));
    assign brstall = BranchD &&
                     ((RegWriteE && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD))) ||
                      (MemtoRegM && (reg_hit(WriteRegM, RsD) || reg_hit(WriteRegM, RtD))));

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        tmo_d     = '0;
        sys_req_d = sys_req_q;
        sys_err_d = 1'b0;
        hold      = lwstall | brstall;
        case (state_q)
            RUN: begin
                if (syscallE) begin
                    hold    = 1'b1;
                    state_d = DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                hold = 1'b1;
                // Leaving on the edge where the count would hit zero puts sys_req up
                // exactly DRAIN_CYCLES edges after the syscall was seen in E.
                if (drain_q <= DW'(1)) begin
                    state_d   = REQ;
                    sys_req_d = 1'b1;
                    drain_d   = '0;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            REQ: begin
                hold  = 1'b1;
                tmo_d = tmo_q + 1'b1;
                if (sys_ack) begin
                    state_d   = RESUME;
                    sys_req_d = 1'b0;
                    tmo_d     = '0;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d   = RESUME;
                    sys_req_d = 1'b0;
                    sys_err_d = 1'b1;
                    tmo_d     = '0;
                end
            end
            RESUME: begin
                state_d   = RUN;
                drain_d   = '0;
                sys_req_d = 1'b0;
            end
            default: begin
                state_d   = RUN;
                drain_d   = '0;
                sys_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            drain_q   <= '0;
            tmo_q     <= '0;
            sys_req_q <= 1'b0;
            sys_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            tmo_q     <= tmo_d;
            sys_req_q <= sys_req_d;
            sys_err_q <= sys_err_d;
        end
    end

    // During reset the pipeline is fed bubbles rather than frozen.
    assign StallF    = reset ? 1'b0   : hold;
    assign StallD    = reset ? 1'b0   : hold;
    assign FlushE    = reset ? 1'b1   : hold;
    assign ForwardAD = reset ? 1'b0   : fwd_ad;
    assign ForwardBD = reset ? 1'b0   : fwd_bd;
    assign ForwardAE = reset ? FWD_RF : fwd_ae;
    assign ForwardBE = reset ? FWD_RF : fwd_be;
    assign sys_req   = sys_req_q;
    assign sys_err   = sys_err_q;
    assign SysActive = (state_q != RUN);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with a queue-based scoreboard and an independent monitor.
module tb_hazard_unit;

    logic       clk, reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, syscallE, sys_ack;
    logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, sys_req, sys_err, SysActive;
    logic [1:0] ForwardAE, ForwardBE;

    hazard_unit #(.DRAIN_CYCLES(2), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .syscallE(syscallE), .sys_ack(sys_ack),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .sys_req(sys_req), .sys_err(sys_err), .SysActive(SysActive)
    );

    // Packed view: StallF StallD FlushE | AD BD | AE[1:0] BE[1:0] | sys_req sys_err SysActive
    logic [11:0] act;
    assign act = {StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
                  sys_req, sys_err, SysActive};

    typedef struct {
        string       name;
        logic [11:0] exp;
        logic [11:0] mask;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        chk_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    errors++;
                    $display("FAIL %s: got %03h want %03h (mask %03h)", e.name, act & e.mask,
                             e.exp & e.mask, e.mask);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string n, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", n, got, want);
        end
    endtask

    task automatic ex(input string n, input logic [11:0] e, input logic [11:0] m);
        chk_t c;
        c.name = n;
        c.exp  = e;
        c.mask = m;
        sb.push_back(c);
    endtask

    task automatic ex_hold(input string n, input logic h);
        ex(n, {h, h, h, 9'b0}, 12'hE00);
    endtask

    task automatic ex_fwd(input string n, input logic [1:0] ae, input logic [1:0] be,
                          input logic ad, input logic bd);
        ex(n, {3'b0, ad, bd, ae, be, 3'b0}, 12'h1F8);
    endtask

    task automatic ex_sys(input string n, input logic h, input logic rq, input logic er,
                          input logic ac);
        ex(n, {h, h, h, 6'b0, rq, er, ac}, 12'hE07);
    endtask

    task automatic clr();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
        syscallE = 0; sys_ack = 0;
    endtask

    task automatic fire_syscall();
        syscallE = 1'b1;
        ex_sys("sc_c0", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        syscallE = 1'b0;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        // A live M->E dependency that reset must mask.
        RsE = 5'd5; RegWriteM = 1'b1; WriteRegM = 5'd5;
        cyc();
        cyc();
        chk_bit("reset_flush_now", FlushE, 1'b1);
        chk_bit("reset_stall_now", StallF, 1'b0);
        chk_bit("reset_req_now", sys_req, 1'b0);
        chk_bit("reset_err_now", sys_err, 1'b0);
        ex("reset_forced", 12'h200, 12'hFFF);
        cyc();
        reset = 1'b0;
        clr();
        cyc();

        // Forwarding
        RsE = 5'd5; RegWriteM = 1; WriteRegM = 5'd5; RegWriteW = 1; WriteRegW = 5'd5;
        ex_fwd("fwd_m_prio", 2'b10, 2'b00, 1'b0, 1'b0);
        ex_hold("fwd_nohold", 1'b0);
        cyc();
        RegWriteM = 0;
        ex_fwd("fwd_w", 2'b01, 2'b00, 1'b0, 1'b0);
        cyc();
        RsE = 0; RegWriteM = 1; WriteRegM = 0; WriteRegW = 0;
        ex_fwd("fwd_zero", 2'b00, 2'b00, 1'b0, 1'b0);
        cyc();
        RtE = 5'd7; WriteRegW = 5'd7; WriteRegM = 5'd3;
        ex_fwd("fwd_be_w", 2'b00, 2'b01, 1'b0, 1'b0);
        cyc();
        clr();

        // Load-use
        MemtoRegE = 1; RtE = 5'd8; RsD = 5'd8;
        ex_hold("lw_rs", 1'b1);
        cyc();
        RsD = 5'd9; RtD = 5'd3;
        ex_hold("lw_none", 1'b0);
        cyc();
        RtD = 5'd8;
        ex_hold("lw_rt", 1'b1);
        cyc();
        RtE = 0; RsD = 0; RtD = 0;
        ex_hold("lw_zero", 1'b0);
        cyc();
        clr();

        // Branch
        BranchD = 1; RegWriteE = 1; WriteRegE = 5'd4; RtD = 5'd4; RsD = 5'd1;
        ex_hold("br_alu_e", 1'b1);
        cyc();
        RegWriteE = 0; MemtoRegM = 1; WriteRegM = 5'd4;
        ex_hold("br_load_m", 1'b1);
        cyc();
        MemtoRegM = 0; RegWriteM = 1;
        ex_hold("br_fwd_ok", 1'b0);
        ex_fwd("br_fwd_bd", 2'b00, 2'b00, 1'b0, 1'b1);
        cyc();
        clr();
        cyc();

        // Syscall with ack at cycle 5; an early ack in DRAIN must be ignored
        fire_syscall();
        sys_ack = 1'b1;
        ex_sys("sc_drain", 1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        sys_ack = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            ex_sys($sformatf("sc_req_c%0d", c), 1'b1, 1'b1, 1'b0, 1'b1);
            cyc();
        end
        sys_ack = 1'b1;
        ex_sys("sc_req_c5", 1'b1, 1'b1, 1'b0, 1'b1);
        cyc();
        sys_ack = 1'b0;
        ex_sys("sc_resume", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        ex_sys("sc_run", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Timeout: no ack, sys_err in cycle 6
        fire_syscall();
        ex_sys("to_drain", 1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        for (int c = 2; c <= 5; c++) begin
            ex_sys($sformatf("to_req_c%0d", c), 1'b1, 1'b1, 1'b0, 1'b1);
            cyc();
        end
        chk_bit("to_err_now", sys_err, 1'b1);
        chk_bit("to_err_req_low", sys_req, 1'b0);
        ex_sys("to_err", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        chk_bit("to_err_one_cycle", sys_err, 1'b0);
        ex_sys("to_run", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Ack coincident with expiry
        fire_syscall();
        cyc();
        cyc();
        cyc();
        cyc();
        sys_ack = 1'b1;
        ex_sys("co_req_c5", 1'b1, 1'b1, 1'b0, 1'b1);
        cyc();
        sys_ack = 1'b0;
        ex_sys("co_noerr", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        ex_sys("co_run", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Reset while in REQ
        fire_syscall();
        cyc();
        cyc();
        reset = 1'b1;
        RsE = 5'd6; RegWriteM = 1; WriteRegM = 6;
        ex("rst_in_req", {3'b001, 6'b0, 3'b101}, 12'hFFF);
        cyc();
        chk_bit("rst_req_now", sys_req, 1'b0);
        chk_bit("rst_active_now", SysActive, 1'b0);
        reset = 1'b0;
        clr();
        ex("rst_after", 12'h000, 12'hFFF);
        cyc();
        ex("rst_stay_run", 12'h000, 12'hFFF);
        cyc();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
